// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//
// Expands up to eight S-bit cluster words per bunch crossing (bx) back into the
// full 24-VFAT x 64-bit chamber S-bit map. Three-stage pipeline, one bx per
// clock, no back-pressure.
//
//   stage 1 : register valid_in and the raw cluster words
//   stage 2 : decode each cluster into row/key/count plus in-range and error flags
//   stage 3 : paint the S-bit map, count in-range clusters, raise err_strobe
//
// Cluster word: [10:0] address (row = adr/192, key = adr%192), [13:11] number of
// adjacent pads hit after the key. Addresses >= 1536 are empty clusters; 0x7FF
// with count 0 is the canonical empty word, anything else out there is a range
// error. Bits that would run past key 191 are dropped and flagged as edge errors.
//
// Optional feature (macro CLUSTER_UNPACKER_ERRCNT_EN): 16-bit saturating range
// and edge error counters, cleared synchronously by counter_reset.
//
// Ports:
//   clock4x        in   sole clock, rising edge
//   global_reset   in   asynchronous active-high reset
//   valid_in       in   qualifies cluster0..cluster7
//   cluster0..7    in   14-bit cluster words
//   counter_reset  in   synchronous clear of the error counters
//   valid_out      out  qualifies sbits / cluster_count (valid_in delayed by 3)
//   sbits          out  1536-bit map, index = vfat*64 + bit
//   cluster_count  out  number of in-range clusters in the bx (0-8)
//   err_strobe     out  one-cycle pulse when the bx had a range or edge error
//   err_range_cnt  out  saturating range-error counter (macro only)
//   err_edge_cnt   out  saturating edge-error counter (macro only)

`timescale 1ns / 1ps

module cluster_unpacker #(
  parameter int unsigned MXSBITS    = 64,
  parameter int unsigned MXCLUSTERS = 8
) (
  input  logic                     clock4x,
  input  logic                     global_reset,
  input  logic                     valid_in,
  input  logic [13:0]              cluster0,
  input  logic [13:0]              cluster1,
  input  logic [13:0]              cluster2,
  input  logic [13:0]              cluster3,
  input  logic [13:0]              cluster4,
  input  logic [13:0]              cluster5,
  input  logic [13:0]              cluster6,
  input  logic [13:0]              cluster7,
  input  logic                     counter_reset,
  output logic                     valid_out,
  output logic [24*MXSBITS-1:0]    sbits,
  output logic [3:0]               cluster_count,
  output logic                     err_strobe
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  ,
  output logic [15:0]              err_range_cnt,
  output logic [15:0]              err_edge_cnt
`endif
);

  localparam int unsigned NumSbits = 24 * MXSBITS;
  localparam logic [10:0] NumAdr   = 11'd1536;
  localparam logic [10:0] EmptyAdr = 11'h7FF;
  localparam logic [8:0]  LastKey  = 9'd191;

  // ---------------------------------------------------------------------------
  // Stage 1: raw capture
  // ---------------------------------------------------------------------------
  logic [13:0] clu_in [MXCLUSTERS];

  assign clu_in[0] = cluster0;
  assign clu_in[1] = cluster1;
  assign clu_in[2] = cluster2;
  assign clu_in[3] = cluster3;
  assign clu_in[4] = cluster4;
  assign clu_in[5] = cluster5;
  assign clu_in[6] = cluster6;
  assign clu_in[7] = cluster7;

  logic        s1_valid_q;
  logic [13:0] s1_clu_q [MXCLUSTERS];

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < MXCLUSTERS; i++) s1_clu_q[i] <= '0;
    end else begin
      s1_valid_q <= valid_in;
      for (int i = 0; i < MXCLUSTERS; i++) s1_clu_q[i] <= clu_in[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-cluster decode
  // ---------------------------------------------------------------------------
  logic [2:0]            row_d  [MXCLUSTERS];
  logic [7:0]            key_d  [MXCLUSTERS];
  logic [2:0]            cnt_d  [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] inr_d;
  logic [MXCLUSTERS-1:0] rerr_d;
  logic [MXCLUSTERS-1:0] eerr_d;

  always_comb begin
    for (int i = 0; i < MXCLUSTERS; i++) begin
      logic [10:0] adr;
      logic [8:0]  last;
      adr       = s1_clu_q[i][10:0];
      cnt_d[i]  = s1_clu_q[i][13:11];
      row_d[i]  = 3'(adr / 11'd192);
      key_d[i]  = 8'(adr % 11'd192);
      last      = {1'b0, key_d[i]} + 9'(cnt_d[i]);
      // An invalid stage is treated as all-empty: no bits, no errors.
      inr_d[i]  = s1_valid_q && (adr < NumAdr);
      rerr_d[i] = s1_valid_q && (adr >= NumAdr) &&
                  ((adr != EmptyAdr) || (cnt_d[i] != 3'd0));
      eerr_d[i] = inr_d[i] && (last > LastKey);
    end
  end

  logic                  s2_valid_q;
  logic [2:0]            s2_row_q [MXCLUSTERS];
  logic [7:0]            s2_key_q [MXCLUSTERS];
  logic [2:0]            s2_cnt_q [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] s2_inr_q;
  logic [MXCLUSTERS-1:0] s2_rerr_q;
  logic [MXCLUSTERS-1:0] s2_eerr_q;

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      s2_valid_q <= 1'b0;
      s2_inr_q   <= '0;
      s2_rerr_q  <= '0;
      s2_eerr_q  <= '0;
      for (int i = 0; i < MXCLUSTERS; i++) begin
        s2_row_q[i] <= '0;
        s2_key_q[i] <= '0;
        s2_cnt_q[i] <= '0;
      end
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_inr_q   <= inr_d;
      s2_rerr_q  <= rerr_d;
      s2_eerr_q  <= eerr_d;
      for (int i = 0; i < MXCLUSTERS; i++) begin
        s2_row_q[i] <= row_d[i];
        s2_key_q[i] <= key_d[i];
        s2_cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: paint the S-bit map
  // ---------------------------------------------------------------------------
  logic [NumSbits-1:0] sbits_d;
  logic [3:0]          cluster_count_d;
  logic                err_strobe_d;
  logic [3:0]          n_range_d;
  logic [3:0]          n_edge_d;

  always_comb begin
    sbits_d = '0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      for (int j = 0; j < 8; j++) begin
        logic [8:0] kk;
        kk = {1'b0, s2_key_q[i]} + 9'(j);
        // Keys past 191 are dropped rather than wrapped into the next row.
        if (s2_inr_q[i] && (3'(j) <= s2_cnt_q[i]) && (kk <= LastKey)) begin
          // vfat = (key/64)*8 + row and bit = key%64 pack as {key[7:6], row, key[5:0]}.
          sbits_d[{kk[7:6], s2_row_q[i], kk[5:0]}] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cluster_count_d = '0;
    n_range_d       = '0;
    n_edge_d        = '0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      cluster_count_d = cluster_count_d + 4'(s2_inr_q[i]);
      n_range_d       = n_range_d + 4'(s2_rerr_q[i]);
      n_edge_d        = n_edge_d + 4'(s2_eerr_q[i]);
    end
    err_strobe_d = (|s2_rerr_q) || (|s2_eerr_q);
  end

  logic                valid_out_q;
  logic [NumSbits-1:0] sbits_q;
  logic [3:0]          cluster_count_q;
  logic                err_strobe_q;

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      valid_out_q     <= 1'b0;
      sbits_q         <= '0;
      cluster_count_q <= '0;
      err_strobe_q    <= 1'b0;
    end else begin
      valid_out_q     <= s2_valid_q;
      sbits_q         <= sbits_d;
      cluster_count_q <= cluster_count_d;
      err_strobe_q    <= err_strobe_d;
    end
  end

  assign valid_out     = valid_out_q;
  assign sbits         = sbits_q;
  assign cluster_count = cluster_count_q;
  assign err_strobe    = err_strobe_q;

  // ---------------------------------------------------------------------------
  // Optional saturating error counters, updated alongside stage 3
  // ---------------------------------------------------------------------------
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  logic [15:0] err_range_cnt_q, err_range_cnt_d;
  logic [15:0] err_edge_cnt_q,  err_edge_cnt_d;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    // Clear wins over a same-cycle increment.
    if (counter_reset) begin
      err_range_cnt_d = '0;
      err_edge_cnt_d  = '0;
    end else begin
      err_range_cnt_d = sat_add(err_range_cnt_q, n_range_d);
      err_edge_cnt_d  = sat_add(err_edge_cnt_q, n_edge_d);
    end
  end

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      err_range_cnt_q <= '0;
      err_edge_cnt_q  <= '0;
    end else begin
      err_range_cnt_q <= err_range_cnt_d;
      err_edge_cnt_q  <= err_edge_cnt_d;
    end
  end

  assign err_range_cnt = err_range_cnt_q;
  assign err_edge_cnt  = err_edge_cnt_q;
`else
  logic [8:0] unused_errcnt;
  assign unused_errcnt = {counter_reset, n_range_d, n_edge_d};
`endif

endmodule
